mem_bist: RTL

//  Parametrised write/readback memory tester; bus master on the word interface (addr/data/we/rd/ack) of ddr3_dev or any
//  ack-handshaked memory. Writes a pattern over a window, reads back, compares, counts errors; optionally loops forever.

---
 rtl/mem_bist_pkg.sv | 26 ++
 rtl/mem_bist_pattern.sv | 48 ++++
 rtl/mem_bist.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the mem_bist write/readback memory tester.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWnx,
    StRd,
    StRnx,
    StDone
  } state_e;

  localparam logic [1:0] ModeIndex = 2'd0;
  localparam logic [1:0] ModeInv   = 2'd1;
  localparam logic [1:0] ModeWalk  = 2'd2;
  localparam logic [1:0] ModeLfsr  = 2'd3;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;
  localparam logic [31:0] LfsrSeed = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Pattern generator for mem_bist: maps (mode, index, LFSR state) to a data word.
module mem_bist_pattern import mem_bist_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  index,
  input  logic [31:0]       seed,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] bit_idx;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_idx = index % CNT_W'(DATA_W);

  always_comb begin
    pattern = '0;
    unique case (mode)
      ModeIndex: pattern = DATA_W'(index);
      ModeInv:   pattern = ~DATA_W'(index);
      ModeWalk:  pattern = DATA_W'(1) << bit_idx;
      ModeLfsr:  pattern = DATA_W'(lfsr_q);
    endcase
  end

endmodule

// File: rtl/mem_bist.sv
// Write/readback memory tester driving an ack-handshaked word bus.
// Define MEM_BIST_ERR_LOG_EN to add first-mismatch capture ports err_addr/err_exp/err_got.
module mem_bist import mem_bist_pkg::*; #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              we_o,
  output logic              rd_o,
  input  logic              ack_i,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [15:0]       pass_cnt,
`ifdef MEM_BIST_ERR_LOG_EN
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got,
`endif
  output logic [CNT_W-1:0]  index_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fail_q, fail_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [15:0]       pass_q, pass_d;
  logic [31:0]       seed_q, seed_d;
  logic              pat_load, pat_step;
  logic [DATA_W-1:0] pattern;
  logic              mismatch;
`ifdef MEM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;
`endif

  // seed_d feeds the generator so a new pass loads the advanced seed directly
  mem_bist_pattern #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_pattern (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode_q),
    .index  (index_q),
    .seed   (seed_d),
    .load   (pat_load),
    .step   (pat_step),
    .pattern(pattern)
  );

  assign mismatch = (data_i != pattern);

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    mode_d   = mode_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    err_d    = err_q;
    pass_d   = pass_q;
    seed_d   = seed_q;
    pat_load = 1'b0;
    pat_step = 1'b0;
`ifdef MEM_BIST_ERR_LOG_EN
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StWr;
          index_d  = '0;
          mode_d   = mode;
          base_d   = base_addr;
          cnt_d    = word_cnt;
          fail_d   = 1'b0;
          err_d    = '0;
          pass_d   = '0;
          pat_load = 1'b1;
`ifdef MEM_BIST_ERR_LOG_EN
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
`endif
        end
      end
      StWr: begin
        if (ack_i) state_d = StWnx;
      end
      StWnx: begin
        if (abort) begin
          state_d = StDone;
        end else if (index_q == cnt_q) begin
          index_d  = '0;
          pat_load = 1'b1;
          state_d  = StRd;
        end else begin
          index_d  = index_q + CNT_W'(1);
          pat_step = 1'b1;
          state_d  = StWr;
        end
      end
      StRd: begin
        if (ack_i) begin
          state_d = StRnx;
          if (mismatch) begin
            fail_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef MEM_BIST_ERR_LOG_EN
            if (!fail_q) begin
              err_addr_d = addr_o;
              err_exp_d  = pattern;
              err_got_d  = data_i;
            end
`endif
            if (STOP_ON_ERR != 0) state_d = StDone;
          end
        end
      end
      StRnx: begin
        if (abort) begin
          state_d = StDone;
        end else if (index_q == cnt_q) begin
          if (loop_en) begin
            pass_d   = pass_q + 16'd1;
            index_d  = '0;
            seed_d   = lfsr_next(seed_q);
            pat_load = 1'b1;
            state_d  = StWr;
          end else begin
            state_d = StDone;
          end
        end else begin
          index_d  = index_q + CNT_W'(1);
          pat_step = 1'b1;
          state_d  = StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      pass_q  <= '0;
      seed_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      seed_q  <= seed_d;
    end
  end

`ifdef MEM_BIST_ERR_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;
`endif

  // Address wraps modulo 2**ADDR_W by construction
  assign addr_o   = base_q + ADDR_W'(index_q) * ADDR_W'(DATA_W / 8);
  assign we_o     = (state_q == StWr);
  assign rd_o     = (state_q == StRd);
  assign data_o   = we_o ? pattern : '0;
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign fail     = fail_q;
  assign err_cnt  = err_q;
  assign pass_cnt = pass_q;
  assign index_o  = index_q;

endmodule
